mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter for the pipelined CPU. It shares one multi-cycle memory port between the instruction-fetch (IF) requester and the data (MEM-stage) requester. It sequences each access through a small state machine and drives a pipeline stall while any request is pending. It also keeps a saturating stall-cycle counter that the bench reads as the stall statistic.

## Interface
Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- LAT, 2, memory read/write latency in cycles (≥1)
- STARVE, 3, consecutive simultaneous-request losses after which IF wins

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  arbitration enable; low blocks new grants
- if_req_i  in  1  IF read request, held until if_ack_o
- if_addr_i  in  ADDR_W  IF address
- if_rdata_o  out  DATA_W  IF read data, valid with if_ack_o
- if_ack_o  out  1  one-cycle completion pulse to IF
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  data read result, valid with dm_ack_o
- dm_ack_o  out  1  one-cycle completion pulse to MEM stage
- mem_en_o  out  1  one-cycle access strobe to memory
- mem_we_o  out  1  write strobe, only with mem_en_o
- mem_addr_o  out  ADDR_W  memory address, held for the whole access
- mem_wdata_o  out  DATA_W  memory write data, held for the whole access
- mem_rdata_i  in  DATA_W  memory read data, valid LAT cycles after the mem_en_o cycle
- stall_o  out  1  pipeline stall
- stall_cnt_o  out  32  count of cycles with stall_o high, saturating

## Operation
- States: IDLE, BUSY, ACK. Owner register holds IF or DM.
- IDLE: grant only when start_i=1 and at least one request is present.
  - Only one requester present: that requester is granted.
  - Both present: DM wins, unless lose_cnt==STARVE, in which case IF wins.
  - lose_cnt increments on each DM win while IF is also requesting. It clears on any IF grant.
- On grant: latch owner, address, we and wdata. An IF grant forces we=0. Go to BUSY, load cnt=LAT.
- BUSY: mem_en_o=1 only in the first BUSY cycle. cnt decrements each edge. On the edge where cnt==1:
  - For a read, sample mem_rdata_i into the owner's rdata register.
  - Go to ACK.
- ACK: assert the owner's ack for exactly one cycle. Next state is IDLE.
- Writes: the owner's rdata register is left unchanged.
- Non-owner request signals are ignored until the state returns to IDLE.
- stall_o = start_i & ((if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o)). This path is combinational.
- stall_cnt_o increments on every edge with stall_o=1 and rst_i=0. It saturates at 0xFFFFFFFF.
- start_i falling while in BUSY or ACK: the in-flight access completes normally. No new grant is made until start_i returns high.

## Timing
- Reset (edge with rst_i=1) sets the following, regardless of state, and abandons any in-flight access:
  - State = IDLE.
  - Owner, lose_cnt and cnt cleared.
  - All outputs 0, including if_rdata_o, dm_rdata_o, mem_* and stall_cnt_o.
- Grant edge E0. Access timeline:
  - mem_en_o is high in cycle E0..E1.
  - mem_rdata_i is sampled at edge E_LAT.
  - ack and rdata are visible in cycle E_LAT..E_LAT+1.
  - IDLE is reached after E_LAT+1.
  - Next grant earliest at E_LAT+2.
- Throughput: one access per LAT+2 cycles.
- The requester deasserts or changes its request at the ack edge. A request still held after ack is treated as a new request.
- mem_addr_o, mem_we_o and mem_wdata_o are stable from E0 until leaving ACK.

## Test plan
- Reset: drive rst_i=1 for 2 edges while both requests are active. Required: all outputs 0, and no mem_en_o for 1 cycle after release.
- IF read, LAT=2, if_addr_i=0x8, mem_rdata_i=0x20080005:
  - mem_en_o high in cycle 1 with mem_addr_o=0x8 and mem_we_o=0.
  - if_ack_o high in cycle 3 with if_rdata_o=0x20080005.
  - stall_cnt_o=3 afterwards.
- Simultaneous requests: DM write (addr 0x4, data 0xA) and IF read (0x0).
  - DM is granted first: mem_we_o=1, dm_ack_o in cycle 3.
  - IF is granted at E4, if_ack_o in cycle 7.
- Starvation: dm_req_i re-asserted immediately after every ack, with if_req_i held.
  - DM wins 3 arbitrations, then IF wins the 4th.
  - lose_cnt returns to 0.
- Reset mid-BUSY: assert rst_i in the cycle after mem_en_o.
  - No ack is ever produced.
  - With requests held, a fresh grant occurs on the first edge after rst_i falls.
- start_i=0 with dm_req_i=1:
  - mem_en_o stays 0 and stall_o=0.
  - Raise start_i: grant at the next edge, mem_en_o the cycle after.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one multi-cycle memory port between IF and DM requesters
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2,
  parameter int STARVE = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int CNT_W  = $clog2(LAT + 1);
  localparam int LOSE_W = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CNT_W-1:0]  LAT_C    = CNT_W'(LAT);
  localparam logic [LOSE_W-1:0] STARVE_C = LOSE_W'(STARVE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = DM owns the port, 0 = IF
  logic [LOSE_W-1:0]   lose_q, lose_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;

  logic if_ack;
  logic dm_ack;
  logic stall;
  logic grant_dm;

  assign if_ack = (state_q == S_ACK) && !owner_q;
  assign dm_ack = (state_q == S_ACK) &&  owner_q;
  assign stall  = start_i & ((if_req_i & ~if_ack) | (dm_req_i & ~dm_ack));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lose_d      = lose_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    stall_cnt_d = stall_cnt_q;
    // DM has priority unless IF has lost STARVE consecutive contested rounds
    grant_dm    = dm_req_i && !(if_req_i && (lose_q == STARVE_C));

    case (state_q)
      S_IDLE: begin
        if (start_i && (if_req_i || dm_req_i)) begin
          owner_d = grant_dm;
          state_d = S_BUSY;
          cnt_d   = LAT_C;
          if (grant_dm) begin
            addr_d  = dm_addr_i;
            we_d    = dm_we_i;
            wdata_d = dm_wdata_i;
            if (if_req_i) begin
              lose_d = lose_q + LOSE_W'(1);
            end
          end else begin
            addr_d  = if_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            lose_d  = '0;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (!we_q) begin
            if (owner_q) dm_rdata_d = mem_rdata_i;
            else         if_rdata_d = mem_rdata_i;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      lose_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lose_q      <= lose_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The strobe marks only the first BUSY cycle; cnt still holds LAT there.
  assign mem_en_o    = (state_q == S_BUSY) && (cnt_q == LAT_C);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = if_ack;
  assign dm_ack_o    = dm_ack;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire
